// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised integer register file with NUM_RD combinational read ports, one
// write port, optional same-cycle write-to-read bypass and a per-register busy
// scoreboard. After reset an init sweep zeroes one entry per cycle. The storage
// array itself has no reset. Entry 0 is hardwired to zero and is never busy.
//
// Ports:
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   rd_addr_i    read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data_o    read data, port k at [k*DATA_W +: DATA_W]
//   busy_o       per-port: addressed register has a pending producer
//   wr_en_i      write enable
//   wr_addr_i    write address
//   wr_data_i    write data
//   sb_set_i     mark register sb_addr_i busy
//   sb_addr_i    scoreboard set address
//   init_done_o  high once the init sweep has completed
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]          busy_o,
    input  logic                       wr_en_i,
    input  logic [ADDR_W-1:0]          wr_addr_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       sb_set_i,
    input  logic [ADDR_W-1:0]          sb_addr_i,
    output logic                       init_done_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   cnt_reg;
    logic                init_done_reg;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    busy_reg;

    logic                run;
    logic                wr_run;
    logic                sb_run;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    assign run    = (state_reg == ST_RUN);
    // Effective write / scoreboard-set: only in RUN, never to entry 0.
    assign wr_run = run && wr_en_i  && (wr_addr_i != '0);
    assign sb_run = run && sb_set_i && (sb_addr_i != '0);

    // -------------------------------------------------------------------------
    // Init sweep FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg     <= ST_INIT;
            cnt_reg       <= '0;
            init_done_reg <= 1'b0;
        end else if (state_reg == ST_INIT) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == {ADDR_W{1'b1}}) begin
                state_reg     <= ST_RUN;
                init_done_reg <= 1'b1;
            end
        end
    end

    assign init_done_o = init_done_reg;

    // -------------------------------------------------------------------------
    // Storage: a single write port shared between the init sweep and the
    // normal writer. Held off while reset is asserted so a stale RUN write
    // cannot land during the reset cycle.
    // -------------------------------------------------------------------------
    assign mem_we    = rst_ni && ((state_reg == ST_INIT) || wr_run);
    assign mem_waddr = (state_reg == ST_INIT) ? cnt_reg : wr_addr_i;
    assign mem_wdata = (state_reg == ST_INIT) ? '0 : wr_data_i;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Busy scoreboard. Set has priority over the clearing write so a new
    // producer issued in the same cycle as the old one completes stays pending.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_reg <= '0;
        end else begin
            busy_reg[0] <= 1'b0;
            for (int i = 1; i < DEPTH; i++) begin
                if (sb_run && (sb_addr_i == ADDR_W'(i))) begin
                    busy_reg[i] <= 1'b1;
                end else if (wr_run && (wr_addr_i == ADDR_W'(i))) begin
                    busy_reg[i] <= 1'b0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hit;
        logic              setting;

        assign addr    = rd_addr_i[gi*ADDR_W +: ADDR_W];
        // wr_run already excludes address 0, so a hit implies addr != 0.
        assign hit     = (BYPASS != 0) && wr_run && (wr_addr_i == addr);
        assign setting = sb_run && (sb_addr_i == addr);

        assign rd_data_o[gi*DATA_W +: DATA_W] =
            (!run || (addr == '0)) ? '0 :
            hit                    ? wr_data_i :
                                     mem[addr];

        // A bypassed completing write hides the busy bit unless a new
        // producer for the same register is being issued this very cycle.
        assign busy_o[gi] = run && busy_reg[addr] && !(hit && !setting);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Directed bench for regfile_mp with default parameters (32x32, 2 read ports,
// bypass enabled). A table of single-cycle vectors covers write, bypass, x0
// and scoreboard behaviour; hand-written sequences cover the init sweep length,
// writes ignored during INIT, and reset mid-RUN / mid-INIT.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     busy;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              sb_set;
    logic [AW-1:0]     sb_addr;
    logic              init_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NUM_RD (NR),
        .BYPASS (1)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .busy_o      (busy),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .sb_set_i    (sb_set),
        .sb_addr_i   (sb_addr),
        .init_done_o (init_done)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ss;
        logic [4:0]  sa;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp_d0;
        logic [31:0] exp_d1;
        logic [1:0]  exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ss, input logic [4:0] sa,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        sb_set  = ss;
        sb_addr = sa;
        rd_addr = {ra1, ra0};
    endtask

    task automatic add_vec(input string nm, input logic we, input logic [4:0] wa,
                           input logic [31:0] wd, input logic ss, input logic [4:0] sa,
                           input logic [4:0] ra0, input logic [4:0] ra1,
                           input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] b);
        vec_t v;
        v.name = nm; v.we = we; v.wa = wa; v.wd = wd; v.ss = ss; v.sa = sa;
        v.ra0 = ra0; v.ra1 = ra1; v.exp_d0 = d0; v.exp_d1 = d1; v.exp_busy = b;
        vecs.push_back(v);
    endtask

    // Counts posedges from reset release (called at a negedge right after
    // rst_n goes high) until init_done is seen; expects exactly 32.
    task automatic count_init(input string nm);
        int  n    = 0;
        bit  seen = 1'b0;
        while (n < 100 && !seen) begin
            @(posedge clk);
            n++;
            #1;
            if (init_done) seen = 1'b1;
            if (n == 10) begin
                check({nm, "_init_rd0"}, rd_data[31:0], 32'h0);
                check({nm, "_init_busy"}, 32'(busy), 32'h0);
            end
        end
        check({nm, "_init_cycles"}, 32'(n), 32'd32);
        @(negedge clk);
    endtask

    task automatic fill_all();
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'h1000_0000 + 32'(i) * 32'h0101, 1'b1, 5'((i % 31) + 1), 5'd0, 5'd0);
            @(negedge clk);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd20);
        #1;
        check("fill_x9", rd_data[31:0], 32'h1000_0000 + 32'd9 * 32'h0101);
        check("fill_x20", rd_data[63:32], 32'h1000_0000 + 32'd20 * 32'h0101);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string nm);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(i), 5'(31 - i));
            #1;
            check($sformatf("%s_x%0d_p0", nm, i), rd_data[31:0], 32'h0);
            check($sformatf("%s_x%0d_p1", nm, 31 - i), rd_data[63:32], 32'h0);
            check($sformatf("%s_busy%0d", nm, i), 32'(busy), 32'h0);
            @(negedge clk);
        end
    endtask

    initial begin
        // Single-cycle vectors, applied in order after the first init sweep.
        //        name          we  wa     wd             ss  sa     ra0    ra1    d0             d1             busy
        add_vec("wr_x7_byp",    1, 5'd7,  32'h1234_5678, 0, 5'd0,  5'd7,  5'd0,  32'h1234_5678, 32'h0,         2'b00);
        add_vec("rd_x7_both",   0, 5'd0,  32'h0,         0, 5'd0,  5'd7,  5'd7,  32'h1234_5678, 32'h1234_5678, 2'b00);
        add_vec("wr_x0_set_x0", 1, 5'd0,  32'hFFFF_FFFF, 1, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         2'b00);
        add_vec("rd_x0_after",  0, 5'd0,  32'h0,         0, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         2'b00);
        add_vec("set_x10",      0, 5'd0,  32'h0,         1, 5'd10, 5'd0,  5'd10, 32'h0,         32'h0,         2'b00);
        add_vec("busy_x10",     0, 5'd0,  32'h0,         0, 5'd0,  5'd0,  5'd10, 32'h0,         32'h0,         2'b10);
        add_vec("wr_x10_clr",   1, 5'd10, 32'hA5A5_A5A5, 0, 5'd0,  5'd10, 5'd10, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 2'b00);
        add_vec("rd_x10_after", 0, 5'd0,  32'h0,         0, 5'd0,  5'd7,  5'd10, 32'h1234_5678, 32'hA5A5_A5A5, 2'b00);
        add_vec("set_wr_x3",    1, 5'd3,  32'h55,        1, 5'd3,  5'd3,  5'd0,  32'h55,        32'h0,         2'b00);
        add_vec("rd_x3_busy",   0, 5'd0,  32'h0,         0, 5'd0,  5'd3,  5'd3,  32'h55,        32'h55,        2'b11);
        add_vec("set_wr_x3_b",  1, 5'd3,  32'h77,        1, 5'd3,  5'd3,  5'd7,  32'h77,        32'h1234_5678, 2'b01);
        add_vec("rd_x3_still",  0, 5'd0,  32'h0,         0, 5'd0,  5'd3,  5'd0,  32'h77,        32'h0,         2'b01);
        add_vec("wr_x3_clr",    1, 5'd3,  32'h88,        0, 5'd0,  5'd3,  5'd3,  32'h88,        32'h88,        2'b00);
        add_vec("rd_x3_free",   0, 5'd0,  32'h0,         0, 5'd0,  5'd3,  5'd10, 32'h88,        32'hA5A5_A5A5, 2'b00);

        // Power-up reset and init sweep; writes and sets to x5 during INIT.
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_init_done", 32'(init_done), 32'h0);
        rst_n = 1'b1;
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd5, 5'd5, 5'd5);
        count_init("por");
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
        #1;
        check("x5_after_init", rd_data[31:0], 32'h0);
        check("x5_busy_after_init", 32'(busy), 32'h0);
        @(negedge clk);

        // Table-driven RUN vectors.
        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ss, vecs[i].sa, vecs[i].ra0, vecs[i].ra1);
            #1;
            check({vecs[i].name, "_d0"}, rd_data[31:0], vecs[i].exp_d0);
            check({vecs[i].name, "_d1"}, rd_data[63:32], vecs[i].exp_d1);
            check({vecs[i].name, "_busy"}, 32'(busy), 32'(vecs[i].exp_busy));
            @(negedge clk);
        end

        // Reset for one cycle in the middle of RUN.
        fill_all();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrun_reset_done", 32'(init_done), 32'h0);
        rst_n = 1'b1;
        count_init("midrun");
        check_all_zero("midrun");

        // Reset again once the sweep counter has reached 17.
        fill_all();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (17) @(negedge clk);
        check("cnt17_done", 32'(init_done), 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        count_init("midinit");
        check_all_zero("midinit");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the single-cycle and upcoming pipelined cores.
- Adds configurable data width, depth and read-port count.
- Adds optional same-cycle write-to-read bypass and a per-register busy scoreboard for long-latency producers such as loads.
- Clears its contents with a sequential init sweep after reset, instead of a wide reset fan-out on the storage array.

Parameters:
DATA_W, 32, data width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of independent read ports (1..4)
BYPASS, 1, 1 = write data forwarded combinationally to matching read ports; 0 = read returns stored value

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; synchronous, active-low; sampled on rising edge of clk_i
rd_addr_i  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rd_data_o  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
busy_o  out  NUM_RD  port k's register has a pending producer
wr_en_i  in  1  write enable
wr_addr_i  in  ADDR_W  write address
wr_data_i  in  DATA_W  write data
sb_set_i  in  1  mark register sb_addr_i busy (producer issued)
sb_addr_i  in  ADDR_W  scoreboard set address
init_done_o  out  1  high once init sweep complete; writes/reads valid

Behaviour:
- Reset (rst_ni=0 at posedge):
  - FSM -> INIT; sweep counter -> 0; all busy bits -> 0; init_done_o -> 0.
  - Storage array is not reset directly.
- FSM states:
  - INIT: each cycle write 0 to entry[counter], then counter+1. When counter == DEPTH-1, perform the final write and go to RUN the next cycle. INIT lasts exactly DEPTH cycles after reset deasserts.
  - RUN: normal operation. Stays in RUN until the next reset.
- init_done_o: registered; 1 exactly when state == RUN.
- During INIT:
  - wr_en_i and sb_set_i are ignored.
  - rd_data_o = 0 and busy_o = 0 on all ports.
- Reset asserted mid-INIT or mid-RUN: restarts INIT from counter 0. Partially written state is discarded, since every entry gets re-zeroed.
- Entry 0 is hardwired zero:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0.
  - Address 0 is never busy.
- Write: in RUN with wr_en_i=1 and wr_addr_i != 0, entry[wr_addr_i] <= wr_data_i at the posedge. Visible to reads in the following cycle.
- Read: combinational, zero latency, per port independently. Any number of ports may read the same address.
- Bypass (BYPASS=1): if wr_en_i=1, wr_addr_i == rd_addr k and rd_addr k != 0, then rd_data k = wr_data_i in the same cycle. BYPASS=0: the stored (old) value is returned that cycle.
- Scoreboard, one busy bit per entry:
  - Set: sb_set_i=1 with sb_addr_i != 0 sets busy[sb_addr_i] at the posedge.
  - Clear: a RUN write with wr_en_i=1 and wr_addr_i != 0 clears busy[wr_addr_i] at the posedge.
  - Same address set and cleared in the same cycle: set wins (new producer supersedes the completing one). The write data is still stored.
- busy_o[k]:
  - Equals busy[rd_addr k].
  - When BYPASS=1, it is forced 0 if the same-cycle write matches rd_addr k and that address is not also being set this cycle. The consumer then takes the bypassed value.
- No backpressure; the block never stalls the writer.

Test Plan:
1. Release reset and count cycles → init_done_o rises exactly 32 cycles after rst_ni goes high (defaults). Writes issued during INIT to x5 (value 0xDEAD_BEEF) → x5 still reads 0 after init.
2. In RUN, write x7 = 0x1234_5678; port0 reads x7 in the same cycle → 0x1234_5678 (BYPASS=1) or 0 (BYPASS=0). Next cycle both ports read x7 → 0x1234_5678.
3. Write x0 = 0xFFFF_FFFF with sb_set_i on x0 → reads of x0 return 0 and busy_o stays 0.
4. sb_set_i on x10; one cycle later busy_o[1] = 1 while port 1 reads x10. Write x10 = 0xA5A5_A5A5 → same-cycle busy_o[1] = 0 with data 0xA5A5_A5A5 (BYPASS=1). Next cycle busy_o[1] = 0.
5. Same cycle: sb_set_i on x3 and write x3 = 0x55 → next cycle x3 reads 0x55 and busy_o = 1 for x3.
6. Fill x1..x31 with nonzero values, assert rst_ni=0 for one cycle mid-RUN → init_done_o = 0 for 32 cycles. After init all registers read 0 and all busy bits are 0. Repeat with reset asserted at INIT counter = 17.
